// File: rtl/serial_adder_arbiter.sv
// Two-requester round-robin front end for one shared bit-serial adder.
// Issues a start pulse, waits for done (or aborts on timeout) and returns the result.
module serial_adder_arbiter #(
  parameter int unsigned N   = 8,
  parameter int unsigned TMO = N + 4
) (
  input  logic         CLOCK_50,
  input  logic         rst,
  input  logic         req0,
  input  logic         req1,
  input  logic [N-1:0] a0,
  input  logic [N-1:0] b0,
  input  logic [N-1:0] a1,
  input  logic [N-1:0] b1,
  input  logic         cin0,
  input  logic         cin1,
  output logic         ack0,
  output logic         ack1,
  output logic [N-1:0] res_s,
  output logic         res_cout,
  output logic         err,
  output logic         busy,
  output logic         adder_start,
  output logic [N-1:0] adder_a,
  output logic [N-1:0] adder_b,
  output logic         adder_cin,
  input  logic [N-1:0] adder_s,
  input  logic         adder_cout,
  input  logic         adder_done,
  output logic         adder_rst
);

  localparam int unsigned CW = $clog2(TMO + 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_t;

  state_t        state_q;
  logic [N-1:0]  op_a_q, op_b_q;
  logic          op_cin_q;
  logic          owner_q;
  logic          rr_ptr_q;
  logic [CW-1:0] wait_cnt_q;

  logic winner;
  logic done_ok;
  logic timeout;
  logic op_drive;

  // rr_ptr_q names the requester that wins a tie.
  assign winner   = (req0 && req1) ? rr_ptr_q : req1;
  // done is stale in the first WAIT cycle, so it only counts from the second one on.
  assign done_ok  = (state_q == StWait) && (wait_cnt_q != '0) && adder_done;
  assign timeout  = (state_q == StWait) && !done_ok && (wait_cnt_q == CW'(TMO - 1));

  assign busy        = (state_q != StIdle);
  assign adder_start = (state_q == StIssue);
  assign op_drive    = (state_q == StIssue) || (state_q == StWait);
  assign adder_a     = op_drive ? op_a_q : '0;
  assign adder_b     = op_drive ? op_b_q : '0;
  assign adder_cin   = op_drive ? op_cin_q : 1'b0;
  assign adder_rst   = rst || timeout;

  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      state_q    <= StIdle;
      op_a_q     <= '0;
      op_b_q     <= '0;
      op_cin_q   <= 1'b0;
      owner_q    <= 1'b0;
      rr_ptr_q   <= 1'b0;
      wait_cnt_q <= '0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      res_s      <= '0;
      res_cout   <= 1'b0;
      err        <= 1'b0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req0 || req1) begin
            op_a_q   <= winner ? a1 : a0;
            op_b_q   <= winner ? b1 : b0;
            op_cin_q <= winner ? cin1 : cin0;
            owner_q  <= winner;
            rr_ptr_q <= ~winner;
            state_q  <= StIssue;
          end
        end
        StIssue: begin
          wait_cnt_q <= '0;
          state_q    <= StWait;
        end
        StWait: begin
          if (done_ok || timeout) begin
            res_s    <= done_ok ? adder_s : '0;
            res_cout <= done_ok ? adder_cout : 1'b0;
            err      <= timeout;
            ack0     <= ~owner_q;
            ack1     <= owner_q;
            state_q  <= StResp;
          end else begin
            wait_cnt_q <= wait_cnt_q + CW'(1);
          end
        end
        StResp: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule
